// File: rtl/btn_pkg.sv
// Shared state encoding and 50 MHz default timing for the button press classifier.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_e;

    localparam int LONG_CYCLES_DEF   = 25_000_000;
    localparam int REPEAT_CYCLES_DEF = 5_000_000;
    localparam int CNT_W_DEF         = 26;
    localparam int EVT_W_DEF         = 8;

endpackage

// File: rtl/button_press_classifier_hold_timer.sv
// Hold-length counter: clr restarts the count, clr with inc counts the restarting cycle itself.
module hold_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] terminal,
    output logic             hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart, advance or hold.
    always_comb begin
        count_d = count_q;
        if (clr && inc) begin
            count_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == terminal);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses as short/long with registered event pulses and a wrapping count.
// Optional auto-repeat while long-held is enabled by defining AUTO_REPEAT_EN.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int EVT_W         = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_db,
    output logic             short_press,
    output logic             long_press,
    output logic             repeat_tick,
    output logic             held,
    output logic [EVT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             btn_q, btn_d;
    logic             short_press_q, short_press_d;
    logic             long_press_q, long_press_d;
    logic             repeat_tick_q, repeat_tick_d;
    logic             held_q, held_d;
    logic [EVT_W-1:0] press_count_q, press_count_d;

    logic             rise_s, fall_s;
    logic             timer_clr_s, timer_inc_s, timer_hit_s;
    logic [CNT_W-1:0] timer_term_s;

    assign rise_s       = btn_db & ~btn_q;
    assign fall_s       = ~btn_db & btn_q;
    assign timer_term_s = (state_q == LONG_HELD) ? REPEAT_TERM : LONG_TERM;

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr_s),
        .inc      (timer_inc_s),
        .terminal (timer_term_s),
        .hit      (timer_hit_s)
    );

    // Next-state and event logic; a fall always takes priority over a timer terminal.
    always_comb begin
        btn_d         = btn_db;
        state_d       = state_q;
        short_press_d = 1'b0;
        long_press_d  = 1'b0;
        repeat_tick_d = 1'b0;
        press_count_d = press_count_q;
        timer_clr_s   = 1'b0;
        timer_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d     = PRESSED;
                    timer_clr_s = 1'b1;
                    timer_inc_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                if (fall_s) begin
                    state_d       = IDLE;
                    short_press_d = 1'b1;
                    press_count_d = press_count_q + {{(EVT_W-1){1'b0}}, 1'b1};
                end else if (timer_hit_s) begin
                    // Restart at zero so each repeat interval spans exactly REPEAT_CYCLES.
                    state_d       = LONG_HELD;
                    long_press_d  = 1'b1;
                    press_count_d = press_count_q + {{(EVT_W-1){1'b0}}, 1'b1};
                    timer_clr_s   = 1'b1;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall_s) begin
                    state_d = IDLE;
`ifdef AUTO_REPEAT_EN
                end else if (timer_hit_s) begin
                    repeat_tick_d = 1'b1;
                    timer_clr_s   = 1'b1;
                end else begin
                    timer_inc_s = 1'b1;
                end
`else
                end else begin
                    state_d = LONG_HELD;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    // State and output registers; btn_q resets high so a button held through reset is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            btn_q         <= 1'b1;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
            repeat_tick_q <= 1'b0;
            held_q        <= 1'b0;
            press_count_q <= {EVT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            btn_q         <= btn_d;
            short_press_q <= short_press_d;
            long_press_q  <= long_press_d;
            repeat_tick_q <= repeat_tick_d;
            held_q        <= held_d;
            press_count_q <= press_count_d;
        end
    end

    assign short_press = short_press_q;
    assign long_press  = long_press_q;
    assign repeat_tick = repeat_tick_q;
    assign held        = held_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Table-driven bench for button_press_classifier (LONG_CYCLES=8, REPEAT_CYCLES=4, EVT_W=3).
module tb_button_press_classifier;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       btn_db;
    logic       short_press;
    logic       long_press;
    logic       repeat_tick;
    logic       held;
    logic [2:0] press_count;

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic       s;
        logic       l;
        logic       t;
        logic       h;
        logic [2:0] c;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    button_press_classifier #(
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (4),
        .EVT_W         (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_db      (btn_db),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .held        (held),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic b, input logic s, input logic l,
                       input logic t, input logic h, input int c);
        vec_t v;
        v.rst_n = r; v.btn = b; v.s = s; v.l = l; v.t = t; v.h = h; v.c = 3'(c);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got s/l/t/h/cnt=%b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d", name,
                     got[6], got[5], got[4], got[3], got[2:0], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    function automatic logic [6:0] outs();
        return {short_press, long_press, repeat_tick, held, press_count};
    endfunction

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        reset  = r;
        btn_db = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset  = 1'b0;
        btn_db = 1'b0;

        // 1: reset with button released
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0);
        // 2: 3-cycle press -> short
        add(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        // 3: 20-cycle hold -> long on the 8th sampled cycle, silent release
        for (int i = 1; i <= 20; i++)
            add(1, 1, 0, (i == 8), (AR && i >= 12 && ((i - 8) % 4) == 0), 1, (i >= 8) ? 2 : 1);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        // 4: release exactly when the timer sits at its terminal -> short only
        for (int i = 0; i < 7; i++) add(1, 1, 0, 0, 0, 1, 2);
        add(1, 0, 1, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 3);
        // 5a: button held through reset is ignored until released
        add(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1);
        // 5b: reset during LONG_HELD aborts silently
        for (int i = 1; i <= 9; i++) add(1, 1, 0, (i == 8), 0, 1, (i >= 8) ? 2 : 1);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // 6: nine 1-cycle presses -> count wraps 7 -> 0 -> 1
        for (int k = 0; k < 9; k++) begin
            add(1, 1, 0, 0, 0, 1, k % 8);
            add(1, 0, 1, 0, 0, 0, (k + 1) % 8);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].btn);
            check($sformatf("row%0d", i), outs(),
                  {vecs[i].s, vecs[i].l, vecs[i].t, vecs[i].h, vecs[i].c});
        end

        // Long-press latency measured with a bounded wait
        n = 0;
        step(1'b1, 1'b1);
        n = 1;
        while (!long_press && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n != 8) begin
            n_bad++;
            $display("FAIL long_latency: got %0d cycles, expected 8", n);
        end
        check("long_count", {short_press, long_press, repeat_tick, held, press_count},
              {1'b0, 1'b1, 1'b0, 1'b1, 3'd2});
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("long_release", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 3'd2});
        step(1'b1, 1'b0);
        check("long_after", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 3'd2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
